// File: rtl/aes_key_expand_seq_pkg.sv
// rtl/aes_key_expand_seq_pkg.sv - shared AES-128 constants, Rcon table and FSM state type
package aes_key_expand_seq_pkg;

  localparam int AES_NR      = 10;
  localparam int AES_NK      = 4;
  localparam int AES_KEY_W   = 128;
  localparam int AES_SCHED_W = AES_KEY_W * (AES_NR + 1);

  typedef enum logic {
    S_IDLE,
    S_EXPAND
  } expand_state_t;

  // Entry 0 is unused so the table index equals the FIPS-197 round number.
  localparam logic [0:10][7:0] AES_RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] aes_rcon(input logic [3:0] round);
    if (round >= 4'd1 && round <= 4'd10) begin
      return AES_RCON[round];
    end
    return 8'h00;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] word);
    return {word[23:0], word[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// rtl/aes_key_expand_seq_if.sv - key expansion request and round-key output bundle
interface aes_key_expand_seq_if;
  import aes_key_expand_seq_pkg::*;

  logic                   start;
  logic [AES_KEY_W-1:0]   Key;
  logic                   busy;
  logic                   done;
  logic                   rk_valid;
  logic [3:0]             rk_idx;
  logic [AES_KEY_W-1:0]   rk;
  logic [AES_SCHED_W-1:0] RoundKeys;

  modport master (
    output start, Key,
    input  busy, done, rk_valid, rk_idx, rk, RoundKeys
  );

  modport slave (
    input  start, Key,
    output busy, done, rk_valid, rk_idx, rk, RoundKeys
  );

endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box, one byte in, one byte out
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] result
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign result = SBOX[data];

endmodule

// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - iterative AES-128 key schedule, one round key per clock
// The working register doubles as the streamed round key; RoundKeys is filled slot by slot.
module aes_key_expand_seq
  import aes_key_expand_seq_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int NK = AES_NK
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_key_expand_seq_if.slave  bus
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  expand_state_t              state;
  logic [3:0]                 idx;
  logic [3:0]                 idx_p1;
  logic [32*NK-1:0]           work;
  logic [128*(NR+1)-1:0]      round_keys;
  logic                       busy;
  logic                       done;
  logic                       rk_valid;

  logic [31:0]                w_cur [NK];
  logic [31:0]                w_nxt [NK];
  logic [31:0]                rot;
  logic [31:0]                sub;
  logic [31:0]                t;
  logic [32*NK-1:0]           next_key;

  assign idx_p1 = idx + 4'd1;

  always_comb begin
    for (int i = 0; i < NK; i++) begin
      w_cur[i] = work[32*(NK-1-i) +: 32];
    end
    rot = rot_word(w_cur[NK-1]);
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .data   (rot[8*g +: 8]),
      .result (sub[8*g +: 8])
    );
  end

  // Each new word chains off the previous new word, so this is a ripple of XORs.
  always_comb begin
    t        = sub ^ {aes_rcon(idx_p1), 24'h0};
    w_nxt[0] = w_cur[0] ^ t;
    for (int i = 1; i < NK; i++) begin
      w_nxt[i] = w_nxt[i-1] ^ w_cur[i];
    end
    next_key = '0;
    for (int i = 0; i < NK; i++) begin
      next_key[32*(NK-1-i) +: 32] = w_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      work       <= '0;
      round_keys <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rk_valid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            work             <= bus.Key;
            round_keys[127:0] <= bus.Key;
            idx              <= '0;
            busy             <= 1'b1;
            rk_valid         <= 1'b1;
            state            <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          if (idx == LAST_IDX) begin
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            state    <= S_IDLE;
          end else begin
            work                                 <= next_key;
            round_keys[128*int'(idx_p1) +: 128]  <= next_key;
            idx                                  <= idx_p1;
            done                                 <= (idx_p1 == LAST_IDX);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.rk_valid  = rk_valid;
  assign bus.rk_idx    = idx;
  assign bus.rk        = work;
  assign bus.RoundKeys = round_keys;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb/tb_aes_key_expand_seq.sv - self-checking bench for aes_key_expand_seq
// Reference schedule uses the FIPS-197 word recurrence with an S-box derived from GF(2^8) inverses.
module tb_aes_key_expand_seq;
  import aes_key_expand_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;

  aes_key_expand_seq_if bus ();

  aes_key_expand_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sbox_ref   [256];
  logic [127:0] sched      [11];
  logic [127:0] slot_model [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic build_schedule(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_ref[tmp[31:24]], sbox_ref[tmp[23:16]], sbox_ref[tmp[15:8]], sbox_ref[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_slots(input string tag);
    for (int s = 0; s < 11; s++) begin
      check($sformatf("%s slot%0d", tag, s), bus.RoundKeys[128*s +: 128], slot_model[s]);
    end
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Entered and left on a falling edge; the rising edge after entry is the accepting edge E0.
  task automatic run_expansion(input logic [127:0] key, input int alter_at, input string tag);
    build_schedule(key);
    bus.start = 1'b1;
    bus.Key   = key;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      slot_model[k] = sched[k];
      check($sformatf("%s rk_idx@%0d", tag, k), 128'(bus.rk_idx), 128'(k));
      check($sformatf("%s rk@%0d", tag, k), bus.rk, sched[k]);
      check($sformatf("%s busy@%0d", tag, k), 128'(bus.busy), 128'(1));
      check($sformatf("%s rk_valid@%0d", tag, k), 128'(bus.rk_valid), 128'(1));
      check($sformatf("%s done@%0d", tag, k), 128'(bus.done), 128'(k == 10));
      check_slots($sformatf("%s @%0d", tag, k));
      if (k == alter_at) bus.Key = '1;
      if (k < 10) @(negedge clk);
    end
    @(negedge clk);
    check({tag, " busy end"}, 128'(bus.busy), 128'(0));
    check({tag, " rk_valid end"}, 128'(bus.rk_valid), 128'(0));
    check({tag, " done end"}, 128'(bus.done), 128'(0));
    check({tag, " rk_idx hold"}, 128'(bus.rk_idx), 128'(10));
    check({tag, " rk hold"}, bus.rk, sched[10]);
    check_slots({tag, " end"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s1 [11];
    logic [127:0] k1;
    logic [127:0] k2;

    for (int x = 0; x < 256; x++) sbox_ref[x] = sbox_math(8'(x));
    for (int s = 0; s < 11; s++) slot_model[s] = '0;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.Key   = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 128'(bus.busy), 128'(0));
    check("reset done", 128'(bus.done), 128'(0));
    check("reset rk_valid", 128'(bus.rk_valid), 128'(0));
    check("reset rk_idx", 128'(bus.rk_idx), 128'(0));
    check("reset rk", bus.rk, 128'(0));
    check_slots("reset");
    rst = 1'b0;
    @(negedge clk);

    run_expansion(128'h2b7e151628aed2a6abf7158809cf4f3c, -1, "fips");
    check("fips round1", bus.RoundKeys[255:128], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips round10", bus.RoundKeys[1407:1280], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_expansion(128'h0, -1, "zero");
    check("zero round1", bus.RoundKeys[255:128], 128'h62636363626363636263636362636363);
    check("zero round10", bus.RoundKeys[1407:1280], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    for (int n = 0; n < 4; n++) run_expansion(rand_key(), -1, $sformatf("rand%0d", n));

    run_expansion(rand_key(), 2, "keychg");

    // start held for 15 edges; a second key appears before E11 and must only be taken at E12.
    k1 = rand_key();
    k2 = rand_key();
    build_schedule(k1);
    for (int r = 0; r < 11; r++) s1[r] = sched[r];
    build_schedule(k2);
    bus.Key   = k1;
    bus.start = 1'b1;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      if (c == 10) bus.Key = k2;
      if (c == 14) bus.start = 1'b0;
      check($sformatf("held done@%0d", c), 128'(bus.done), 128'(c == 10 || c == 22));
      check($sformatf("held busy@%0d", c), 128'(bus.busy), 128'(c <= 10 || (c >= 12 && c <= 22)));
      if (c == 10) check("held rk first", bus.rk, s1[10]);
      if (c == 22) check("held rk second", bus.rk, sched[10]);
    end
    for (int s = 0; s < 11; s++) slot_model[s] = sched[s];
    check_slots("held end");

    bus.Key   = rand_key();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 11; s++) slot_model[s] = '0;
    check("midrst busy", 128'(bus.busy), 128'(0));
    check("midrst rk_valid", 128'(bus.rk_valid), 128'(0));
    check("midrst done", 128'(bus.done), 128'(0));
    check("midrst rk_idx", 128'(bus.rk_idx), 128'(0));
    check_slots("midrst");
    rst = 1'b0;
    @(negedge clk);
    run_expansion(rand_key(), -1, "postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
